// File: rtl/labcontrol_pkg.sv
// Shared LabControl bus definitions: field widths, DIOD bit map, FSM state encoding
// and the packing helper used by the bus masters and receivers.
package labcontrol_pkg;

    localparam int unsigned LC_DATA_WIDTH = 16;
    localparam int unsigned LC_ADDR_WIDTH = 8;
    localparam int unsigned LC_SBUS_WIDTH = 3;
    localparam int unsigned LC_RESV_WIDTH = 3;
    localparam int unsigned LC_BUS_WIDTH  = 32;

    // Bit positions inside DIOD
    localparam int unsigned LC_STROBE_BIT = 0;
    localparam int unsigned LC_DIR_BIT    = 1;
    localparam int unsigned LC_SBUS_LSB   = 2;
    localparam int unsigned LC_RESV_LSB   = 5;

    typedef enum logic [1:0] {
        LC_ST_IDLE   = 2'd0,
        LC_ST_SETUP  = 2'd1,
        LC_ST_STROBE = 2'd2,
        LC_ST_HOLD   = 2'd3
    } lc_state_t;

    // Full 32-bit bus image; field order maps directly onto {DIOA, DIOB, DIOC, DIOD}
    typedef struct packed {
        logic [LC_DATA_WIDTH-1:0] data;
        logic [LC_ADDR_WIDTH-1:0] addr;
        logic [LC_RESV_WIDTH-1:0] resv;
        logic [LC_SBUS_WIDTH-1:0] sbus;
        logic                     dir;
        logic                     strobe;
    } lc_bus_t;

    function automatic lc_bus_t lc_pack(
        input logic [LC_DATA_WIDTH-1:0] data,
        input logic [LC_ADDR_WIDTH-1:0] addr,
        input logic [LC_SBUS_WIDTH-1:0] sbus,
        input logic                     dir,
        input logic                     strobe
    );
        lc_bus_t b;
        b.data   = data;
        b.addr   = addr;
        b.resv   = '0;
        b.sbus   = sbus;
        b.dir    = dir;
        b.strobe = strobe;
        return b;
    endfunction

endpackage

// File: rtl/axis_labcontrol_master.sv
// LabControl bus master: turns each AXI-Stream command word into a timed
// setup / strobe / hold write cycle on the DIOA..DIOD bus.
module axis_labcontrol_master
    import labcontrol_pkg::lc_state_t, labcontrol_pkg::lc_bus_t, labcontrol_pkg::lc_pack,
           labcontrol_pkg::LC_ST_IDLE, labcontrol_pkg::LC_ST_SETUP,
           labcontrol_pkg::LC_ST_STROBE, labcontrol_pkg::LC_ST_HOLD;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned LC_DATA_WIDTH   = 16,
    parameter int unsigned LC_ADDR_WIDTH   = 8,
    parameter int unsigned SETUP_CYCLES    = 2,
    parameter int unsigned STROBE_CYCLES   = 10,
    parameter int unsigned HOLD_CYCLES     = 2
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       busy,
    output logic [7:0]                 DIOA,
    output logic [7:0]                 DIOB,
    output logic [7:0]                 DIOC,
    output logic [7:0]                 DIOD
);

    localparam int unsigned CMD_WIDTH  = 27;
    localparam int unsigned SBUS_LSB   = LC_DATA_WIDTH + LC_ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH  = 8;

    localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);

    lc_state_t            state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    lc_bus_t              bus, bus_next;
    logic                 ready_q;
    logic                 busy_q;
    logic                 accept_c;

    // Bits above the subbus field carry no meaning for this bus
    generate
        if (AXIS_DATA_WIDTH > CMD_WIDTH) begin : g_unused_tdata
            logic unused_tdata;
            assign unused_tdata = ^s_axis_tdata[AXIS_DATA_WIDTH-1:CMD_WIDTH];
        end
    endgenerate

    assign accept_c = s_axis_tvalid && ready_q;

    // Next-state, phase counter and bus image
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bus_next   = bus;
        case (state)
            LC_ST_IDLE: begin
                if (accept_c) begin
                    state_next = LC_ST_SETUP;
                    cnt_next   = SETUP_LOAD;
                    bus_next   = lc_pack(s_axis_tdata[LC_DATA_WIDTH-1:0],
                                         s_axis_tdata[LC_DATA_WIDTH +: LC_ADDR_WIDTH],
                                         s_axis_tdata[SBUS_LSB +: 3],
                                         1'b1, 1'b0);
                end
            end
            LC_ST_SETUP: begin
                if (cnt == '0) begin
                    state_next      = LC_ST_STROBE;
                    cnt_next        = STROBE_LOAD;
                    bus_next.strobe = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            LC_ST_STROBE: begin
                if (cnt == '0) begin
                    state_next      = LC_ST_HOLD;
                    cnt_next        = HOLD_LOAD;
                    bus_next.strobe = 1'b0;
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            LC_ST_HOLD: begin
                if (cnt == '0) begin
                    state_next = LC_ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next = LC_ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Ready/busy are registered copies of the state decode; ready stays low while in reset
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state   <= LC_ST_IDLE;
            cnt     <= '0;
            bus     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bus     <= bus_next;
            ready_q <= (state_next == LC_ST_IDLE);
            busy_q  <= (state_next != LC_ST_IDLE);
        end
    end

    assign s_axis_tready = ready_q;
    assign busy          = busy_q;
    assign DIOA          = bus.data[15:8];
    assign DIOB          = bus.data[7:0];
    assign DIOC          = bus.addr;
    assign DIOD          = {bus.resv, bus.sbus, bus.dir, bus.strobe};

endmodule

// File: doc/axis_labcontrol_master.md
# axis_labcontrol_master

Transmit side of the LabControl parallel bus. Accepts command words on an AXI4-Stream slave port and replays each one as a timed LabControl write cycle on the 32-bit DIOA..DIOD bus: setup, strobe pulse, hold. It is the bus master that drives the address/data/strobe lines sampled by `axis_labcontrol_interface` receivers. It lets a PL or PS stream source address any LabControl device.

## Interface
- `AXIS_DATA_WIDTH`, 32: stream word width. Must be ≥ 27.
- `LC_DATA_WIDTH`, 16: LabControl data field width. Fixed at 16.
- `LC_ADDR_WIDTH`, 8: LabControl address field width. Fixed at 8.
- `SETUP_CYCLES`, 2: cycles that addr/data are stable before strobe rises. Range 1..255.
- `STROBE_CYCLES`, 10: strobe high time in cycles. Range 1..255.
- `HOLD_CYCLES`, 2: cycles that addr/data are held after strobe falls. Range 1..255.

Ports:
- `s_axis_aclk`  in  1  sole clock.
- `s_axis_aresetn`  in  1  reset. Synchronous, active-low.
- `s_axis_tdata`  in  AXIS_DATA_WIDTH  command word:
  - [15:0] data
  - [23:16] addr
  - [26:24] subbus
  - upper bits ignored.
- `s_axis_tvalid`  in  1  command valid.
- `s_axis_tready`  out  1  block idle, command accepted this cycle if tvalid.
- `busy`  out  1  bus cycle in progress (state ≠ IDLE).
- `DIOA`  out  8  data[15:8].
- `DIOB`  out  8  data[7:0].
- `DIOC`  out  8  addr.
- `DIOD`  out  8  {reserved[2:0]=0, subbus[2:0], dir, strobe}.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on tvalid && tready.
  - SETUP → STROBE after SETUP_CYCLES.
  - STROBE → HOLD after STROBE_CYCLES.
  - HOLD → IDLE after HOLD_CYCLES.
- Phase lengths come from one 8-bit down-counter. It is loaded with N-1 on each phase entry, and the phase ends when it reads 0.
- `s_axis_tready` = (state == IDLE). It is decoded from the state register only and never depends on tvalid.
- On accept, the bus registers load data, addr and subbus from tdata, with dir=1 (write), strobe=0 and reserved=0.
- strobe=1 exactly during STROBE. data, addr, subbus and dir are constant from the first SETUP cycle through the last HOLD cycle.
- In IDLE the bus keeps the last data/addr/subbus/dir with strobe=0. No glitch or change occurs until the next accept.
- No buffering: at most one command is in flight, and the source is back-pressured while busy.
- All DIO outputs come straight from flops, with no combinational path from inputs.

## Timing
- Reset (s_axis_aresetn=0 at an edge): state=IDLE, all DIOA..DIOD=0 (strobe=0, dir=0), busy=0. tready=1 from the first cycle after reset deasserts.
- Reset mid-cycle, in any state: the next edge forces IDLE with strobe=0 and all DIO=0. The in-flight command is dropped and not replayed.
- Accept at edge k:
  - New fields are visible on DIO during cycle k+1.
  - strobe rises at edge k+SETUP_CYCLES.
  - strobe falls at edge k+SETUP_CYCLES+STROBE_CYCLES.
  - IDLE is reached, with tready=1, at edge k+S+T+H.
- Per-command period with tvalid held high is 1+S+T+H cycles: 15 with defaults.
- tvalid deasserted while busy has no effect. tdata changes while busy are ignored.
- Command accepted in the first IDLE cycle after HOLD: back-to-back cycles keep strobe low for exactly H+1+S cycles between pulses.
- A command whose addr equals the previous one is still replayed as a full cycle, with no suppression.

## Structure
- Shared package `labcontrol_pkg` holds the items common to this block and `axis_labcontrol_interface`:
  - field widths (LC_DATA_WIDTH, LC_ADDR_WIDTH, LC_SBUS_WIDTH=3, LC_RESV_WIDTH=3);
  - bus bit positions (strobe bit 0, dir bit 1, subbus [4:2], reserved [7:5] of DIOD);
  - the FSM state enum;
  - a packing function from fields to the 32-bit bus.
- No sub-module. FSM, phase counter and bus registers live in one module.

## Test plan
- Reset: hold aresetn=0 for 3 cycles with tvalid=1 → DIO all 0x00, tready=0, busy=0. tready=1 on the first cycle after release.
- Single write: tdata=0x0011_5353 → for 15 cycles DIOA=0x53, DIOB=0x53, DIOC=0x11, DIOD=0x02. Then DIOD=0x03 for exactly 10 cycles starting 2 cycles after accept, then DIOD=0x02 for 2 cycles. tready returns 15 cycles after accept.
- Back-to-back: tvalid held with 0x0011_8181 then 0x0022_F33F → two strobe pulses of 10 cycles with a 5-cycle low gap. DIOC changes 0x11→0x22 only after the first HOLD ends.
- Subbus: tdata=0x0501_ABCD → DIOD=0x16 during SETUP/HOLD and 0x17 during STROBE. The upper tdata bits have no effect.
- Reset mid-strobe: assert aresetn=0 on the 4th strobe cycle → strobe=0 and DIO=0 the next cycle, then IDLE with no replay of the word.
- Parameter sweep: S=T=H=1 → 4-cycle period and a 1-cycle strobe, checked against a scoreboard of expected bus values over 100 random commands.
